// File: rtl/bdcc_rx_word.sv
// bdcc_rx_word: BDCC serial word receiver.
// Arms on an HO high run of HO_MIN clocks, then shifts in DATA_W bits
// delivered as IM1 (one) / IM0 (zero) pulses, MSB first, and strobes the
// finished word on oVal. Flags frame abort, bit timeout, collision and
// (optionally) parity errors, and counts good words.
// Optional build macro: RX_PARITY_EN adds a trailing odd-parity bit.
module bdcc_rx_word #(
  parameter int DATA_W = 16,
  parameter int HO_MIN = 7,
  parameter int BIT_TO = 255,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              HO,
  input  logic              IM1,
  input  logic              IM0,
  output logic [DATA_W-1:0] oData,
  output logic              oVal,
  output logic              oSync,
  output logic              oErr,
  output logic [1:0]        oErrCode,
  output logic [CNT_W-1:0]  oWordCnt
);

`ifdef RX_PARITY_EN
  localparam int NBITS = DATA_W + 1;
  localparam int SR_W  = DATA_W;
`else
  localparam int NBITS = DATA_W;
  localparam int SR_W  = DATA_W - 1;
`endif

  localparam int HO_W = $clog2(HO_MIN + 1);
  localparam int TO_W = $clog2(BIT_TO);
  localparam int BC_W = $clog2(NBITS + 1);

  localparam logic [HO_W-1:0] HO_LAST  = HO_W'(HO_MIN - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(BIT_TO - 1);
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(NBITS - 1);

  typedef enum logic [1:0] {
    S_WAITLO = 2'd0,
    S_HOCNT  = 2'd1,
    S_ARMED  = 2'd2,
    S_DATA   = 2'd3
  } state_t;

  state_t state, state_n;

  // Input pipeline; HO is only ever used as a level, so it needs no second stage.
  logic ho_d1, im1_d1, im1_d2, im0_d1, im0_d2;
  logic e1, e0;

  logic [HO_W-1:0]   hoCnt, ho_n;
  logic [TO_W-1:0]   toCnt, to_n;
  logic [BC_W-1:0]   bitCnt, bc_n;
  logic [SR_W-1:0]   sr, sr_n;
  logic [SR_W:0]     shift;
  logic [DATA_W-1:0] data_n;
  logic [1:0]        code_n;
  logic [CNT_W-1:0]  cnt_n;
  logic              val_n, sync_n, err_n;

  assign e1    = im1_d1 & ~im1_d2;
  assign e0    = im0_d1 & ~im0_d2;
  assign shift = {sr, e1};

  // Two-stage synchroniser/edge pipeline for the line inputs.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      ho_d1  <= 1'b0;
      im1_d1 <= 1'b0;
      im1_d2 <= 1'b0;
      im0_d1 <= 1'b0;
      im0_d2 <= 1'b0;
    end else begin
      ho_d1  <= HO;
      im1_d1 <= IM1;
      im1_d2 <= im1_d1;
      im0_d1 <= IM0;
      im0_d2 <= im0_d1;
    end
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (!nRST) begin
      state    <= S_WAITLO;
      hoCnt    <= '0;
      toCnt    <= '0;
      bitCnt   <= '0;
      sr       <= '0;
      oData    <= '0;
      oVal     <= 1'b0;
      oSync    <= 1'b0;
      oErr     <= 1'b0;
      oErrCode <= '0;
      oWordCnt <= '0;
    end else begin
      state    <= state_n;
      hoCnt    <= ho_n;
      toCnt    <= to_n;
      bitCnt   <= bc_n;
      sr       <= sr_n;
      oData    <= data_n;
      oVal     <= val_n;
      oSync    <= sync_n;
      oErr     <= err_n;
      oErrCode <= code_n;
      oWordCnt <= cnt_n;
    end
  end

  // Next-state and output decode; S_DATA checks are in priority order.
  always_comb begin
    state_n = state;
    ho_n    = hoCnt;
    to_n    = toCnt;
    bc_n    = bitCnt;
    sr_n    = sr;
    data_n  = oData;
    val_n   = 1'b0;
    sync_n  = 1'b0;
    err_n   = 1'b0;
    code_n  = oErrCode;
    cnt_n   = oWordCnt;

    unique case (state)
      S_WAITLO: begin
        if (!ho_d1) begin
          state_n = S_HOCNT;
          ho_n    = '0;
        end
      end

      S_HOCNT: begin
        if (ho_d1) begin
          if (hoCnt == HO_LAST) begin
            sync_n  = 1'b1;
            state_n = S_ARMED;
            ho_n    = '0;
          end else begin
            ho_n = hoCnt + HO_W'(1);
          end
        end else begin
          ho_n = '0;
        end
      end

      S_ARMED: begin
        if (!ho_d1) begin
          state_n = S_DATA;
          bc_n    = '0;
          to_n    = '0;
          sr_n    = '0;
        end
      end

      S_DATA: begin
        if (ho_d1) begin
          // A new marker mid-word counts as the first clock of the next run.
          err_n   = 1'b1;
          code_n  = 2'd0;
          state_n = S_HOCNT;
          ho_n    = HO_W'(1);
        end else if (e1 && e0) begin
          err_n   = 1'b1;
          code_n  = 2'd2;
          state_n = S_WAITLO;
        end else if (e1 || e0) begin
          sr_n = shift[SR_W-1:0];
          bc_n = bitCnt + BC_W'(1);
          to_n = '0;
          if (bitCnt == BIT_LAST) begin
            state_n = S_WAITLO;
`ifdef RX_PARITY_EN
            // sr already holds the data word; the parity bit is the incoming one.
            if (^shift) begin
              data_n = sr;
              val_n  = 1'b1;
              cnt_n  = oWordCnt + CNT_W'(1);
            end else begin
              err_n  = 1'b1;
              code_n = 2'd3;
            end
`else
            data_n = shift;
            val_n  = 1'b1;
            cnt_n  = oWordCnt + CNT_W'(1);
`endif
          end
        end else begin
          if (toCnt == TO_LAST) begin
            err_n   = 1'b1;
            code_n  = 2'd1;
            state_n = S_WAITLO;
          end else begin
            to_n = toCnt + TO_W'(1);
          end
        end
      end

      default: state_n = S_WAITLO;
    endcase
  end

endmodule

// File: tb/tb_bdcc_rx_word.sv
// Directed scoreboard bench for bdcc_rx_word (default parameters).
module tb_bdcc_rx_word;
  localparam int DATA_W = 16;
  localparam int HO_MIN = 7;
  localparam int BIT_TO = 255;
  localparam int CNT_W  = 16;

  logic clk = 1'b0;
  logic nRST = 1'b0;
  logic HO = 1'b0, IM1 = 1'b0, IM0 = 1'b0;
  logic [DATA_W-1:0] oData;
  logic oVal, oSync, oErr;
  logic [1:0] oErrCode;
  logic [CNT_W-1:0] oWordCnt;

  int tests = 0, failed = 0;
  int cyc = 0;
  int sync_cnt = 0, err_cnt = 0, val_cnt = 0;
  int sync_cyc = 0, err_cyc = 0, val_cyc = 0, last_pulse_cyc = 0;
  logic [1:0] last_code = '0;
  logic prev_val = 1'b0;
  logic [CNT_W-1:0] exp_cnt = '0;
  int s0, e0, v0;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [CNT_W-1:0]  c;
  } exp_t;
  exp_t sb[$];

  bdcc_rx_word #(.DATA_W(DATA_W), .HO_MIN(HO_MIN), .BIT_TO(BIT_TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .nRST(nRST), .HO(HO), .IM1(IM1), .IM0(IM0),
    .oData(oData), .oVal(oVal), .oSync(oSync), .oErr(oErr),
    .oErrCode(oErrCode), .oWordCnt(oWordCnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: strobe bookkeeping and scoreboard pop on every oVal.
  always @(negedge clk) begin
    if (oSync) begin sync_cnt++; sync_cyc = cyc; end
    if (oErr) begin err_cnt++; err_cyc = cyc; last_code = oErrCode; end
    if (oVal) begin
      val_cnt++;
      val_cyc = cyc;
      check("oVal_single_cycle", 32'(prev_val), 32'd0);
      check("sb_nonempty_on_val", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("oData_word", 32'(oData), 32'(e.d));
        check("oWordCnt_word", 32'(oWordCnt), 32'(e.c));
      end
    end
    prev_val = oVal;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic b);
    last_pulse_cyc = cyc;
    if (b) IM1 = 1'b1; else IM0 = 1'b1;
    tick(1);
    IM1 = 1'b0;
    IM0 = 1'b0;
    tick(2);
  endtask

  task automatic arm();
    HO = 1'b0; tick(3);
    HO = 1'b1; tick(HO_MIN);
    HO = 1'b0; tick(2);
  endtask

  task automatic send_data(input logic [DATA_W-1:0] w, input int nb);
    for (int i = DATA_W - 1; i >= DATA_W - nb; i--) pulse(w[i]);
  endtask

  task automatic send_word(input logic [DATA_W-1:0] w);
    exp_t e;
    exp_cnt = exp_cnt + CNT_W'(1);
    e.d = w;
    e.c = exp_cnt;
    sb.push_back(e);
    send_data(w, DATA_W);
`ifdef RX_PARITY_EN
    pulse(~^w);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_oData"}, 32'(oData), 32'd0);
    check({tag, "_oVal"}, 32'(oVal), 32'd0);
    check({tag, "_oSync"}, 32'(oSync), 32'd0);
    check({tag, "_oErr"}, 32'(oErr), 32'd0);
    check({tag, "_oErrCode"}, 32'(oErrCode), 32'd0);
    check({tag, "_oWordCnt"}, 32'(oWordCnt), 32'd0);
  endtask

  initial begin
    // Reset defaults
    nRST = 1'b0;
    tick(3);
    check_reset_outputs("reset");
    nRST = 1'b1;
    tick(3);

    // Short HO run (HO_MIN-1) must not arm; pulses ignored
    s0 = sync_cnt; e0 = err_cnt; v0 = val_cnt;
    HO = 1'b1; tick(HO_MIN - 1);
    HO = 1'b0; tick(2);
    send_data(16'hA5C3, DATA_W);
    tick(4);
    check("short_ho_no_sync", 32'(sync_cnt - s0), 32'd0);
    check("short_ho_no_val", 32'(val_cnt - v0), 32'd0);
    check("short_ho_no_err", 32'(err_cnt - e0), 32'd0);
    check("short_ho_oData", 32'(oData), 32'd0);

    // Basic frame 0xA5C3
    s0 = sync_cnt; v0 = val_cnt;
    arm();
    check("basic_sync_once", 32'(sync_cnt - s0), 32'd1);
    send_word(16'hA5C3);
    tick(4);
    check("basic_val_once", 32'(val_cnt - v0), 32'd1);
    check("basic_latency", 32'(val_cyc - last_pulse_cyc), 32'd2);
    check("basic_oData", 32'(oData), 32'hA5C3);
    check("basic_oWordCnt", 32'(oWordCnt), 32'd1);

    // Bit timeout after 5 bits, then a good frame 0x0001
    e0 = err_cnt; v0 = val_cnt;
    arm();
    send_data(16'hFFFF, 5);
    tick(BIT_TO + 10);
    check("timeout_err", 32'(err_cnt - e0), 32'd1);
    check("timeout_code", 32'(last_code), 32'd1);
    check("timeout_cycle", 32'(err_cyc - last_pulse_cyc), 32'(BIT_TO + 2));
    check("timeout_no_val", 32'(val_cnt - v0), 32'd0);
    check("timeout_oData_kept", 32'(oData), 32'hA5C3);
    arm();
    send_word(16'h0001);
    tick(4);
    check("after_to_oData", 32'(oData), 32'h0001);
    check("after_to_val", 32'(val_cnt - v0), 32'd1);

    // Collision on bit 3
    e0 = err_cnt; v0 = val_cnt;
    arm();
    send_data(16'h5000, 3);
    IM1 = 1'b1; IM0 = 1'b1; tick(1);
    IM1 = 1'b0; IM0 = 1'b0; tick(4);
    check("collision_err", 32'(err_cnt - e0), 32'd1);
    check("collision_code", 32'(last_code), 32'd2);
    check("collision_cnt", 32'(oWordCnt), 32'(exp_cnt));
    check("collision_oData", 32'(oData), 32'h0001);
    check("collision_no_val", 32'(val_cnt - v0), 32'd0);

    // Frame abort by HO after bit 8, HO held HO_MIN total -> re-sync
    e0 = err_cnt; s0 = sync_cnt;
    arm();
    s0 = sync_cnt;
    send_data(16'h1234, 8);
    HO = 1'b1; tick(HO_MIN);
    HO = 1'b0; tick(2);
    check("abort_err", 32'(err_cnt - e0), 32'd1);
    check("abort_code", 32'(last_code), 32'd0);
    check("abort_resync", 32'(sync_cnt - s0), 32'd1);
    check("abort_sync_after_err", 32'(sync_cyc > err_cyc), 32'd1);
    check("abort_oData_kept", 32'(oData), 32'h0001);
    send_word(16'hFFFF);
    tick(4);
    check("abort_next_oData", 32'(oData), 32'hFFFF);

`ifdef RX_PARITY_EN
    // Parity: good then bad
    v0 = val_cnt; e0 = err_cnt;
    arm();
    exp_cnt = exp_cnt + CNT_W'(1);
    sb.push_back('{16'h0003, exp_cnt});
    send_data(16'h0003, DATA_W);
    pulse(1'b1);
    tick(4);
    check("parity_good_val", 32'(val_cnt - v0), 32'd1);
    check("parity_good_oData", 32'(oData), 32'h0003);
    arm();
    send_data(16'h0003, DATA_W);
    pulse(1'b0);
    tick(4);
    check("parity_bad_err", 32'(err_cnt - e0), 32'd1);
    check("parity_bad_code", 32'(last_code), 32'd3);
    check("parity_bad_no_val", 32'(val_cnt - v0), 32'd1);
    check("parity_bad_oData", 32'(oData), 32'h0003);
    check("parity_bad_cnt", 32'(oWordCnt), 32'(exp_cnt));
`endif

    // Reset mid-frame discards the partial word
    e0 = err_cnt;
    arm();
    send_data(16'hF000, 4);
    nRST = 1'b0;
    tick(1);
    check_reset_outputs("midreset");
    tick(1);
    check("midreset_no_err", 32'(err_cnt - e0), 32'd0);
    nRST = 1'b1;
    exp_cnt = '0;
    tick(2);
    arm();
    send_word(16'h8001);
    tick(4);
    check("postreset_oData", 32'(oData), 32'h8001);
    check("postreset_cnt", 32'(oWordCnt), 32'd1);

    tick(2);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Absolute time bound in case the stimulus ever stalls.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
